mips_multicycle_controller: RTL

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives datapath enables and mux selects. It is the producer of the 2-bit alu_op that the ALU decoder consumes: 00 = add, 01 = subtract, 10 = use funct. Memory accesses use a ready handshake so that slow memory stalls the FSM.

---
 rtl/mips_multicycle_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback steps and drives datapath enables and selects.
module mips_multicycle_controller #(
   parameter int OP_W     = 6,
   parameter int ALU_OP_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                branch,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal_op
);

   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

   localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(2'b00);
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(2'b01);
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2'b10);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
   } state_t;

   state_t state;
   state_t state_next;
   logic   opcode_legal;

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
         default:                                   opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_IDLE:     state_next = S_FETCH;
         S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_next = S_MEMREAD;
            else if (opcode == OP_SW) state_next = S_MEMWRITE;
            else                      state_next = S_FETCH;
         end
         S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  state_next = S_ALUWB;
         S_BRANCH:   state_next = S_FETCH;
         S_ADDIEX:   state_next = S_ADDIWB;
         default:    state_next = S_FETCH;
      endcase
   end

   // Moore outputs are registered from the next state so they change with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mem_req    <= 1'b0;
         iord       <= 1'b0;
         branch     <= 1'b0;
         reg_write  <= 1'b0;
         reg_dst    <= 1'b0;
         mem_to_reg <= 1'b0;
         alu_src_a  <= 1'b0;
         alu_src_b  <= 2'b00;
         pc_src     <= 2'b00;
         alu_op     <= ALU_ADD;
      end else begin
         state      <= state_next;
         mem_req    <= 1'b0;
         iord       <= 1'b0;
         branch     <= 1'b0;
         reg_write  <= 1'b0;
         reg_dst    <= 1'b0;
         mem_to_reg <= 1'b0;
         alu_src_a  <= 1'b0;
         alu_src_b  <= 2'b00;
         pc_src     <= 2'b00;
         alu_op     <= ALU_ADD;
         case (state_next)
            S_FETCH: begin
               mem_req   <= 1'b1;
               alu_src_b <= 2'b01;
            end
            S_DECODE:  alu_src_b <= 2'b11;
            S_MEMADR, S_ADDIEX: begin
               alu_src_a <= 1'b1;
               alu_src_b <= 2'b10;
            end
            S_MEMREAD, S_MEMWRITE: begin
               mem_req <= 1'b1;
               iord    <= 1'b1;
            end
            S_MEMWB: begin
               reg_write  <= 1'b1;
               mem_to_reg <= 1'b1;
            end
            S_EXECUTE: begin
               alu_src_a <= 1'b1;
               alu_op    <= ALU_FUNCT;
            end
            S_ALUWB: begin
               reg_write <= 1'b1;
               reg_dst   <= 1'b1;
            end
            S_BRANCH: begin
               alu_src_a <= 1'b1;
               alu_op    <= ALU_SUB;
               branch    <= 1'b1;
               pc_src    <= 2'b01;
            end
            S_ADDIWB:  reg_write <= 1'b1;
            S_JUMP:    pc_src    <= 2'b10;
            default: ;
         endcase
      end
   end

   // Strobes qualified by the memory handshake follow mem_ready in the same cycle.
   assign ir_write   = (state == S_FETCH) && mem_ready;
   assign pc_write   = ((state == S_FETCH) && mem_ready) || (state == S_JUMP);
   assign mem_write  = (state == S_MEMWRITE) && mem_ready;
   assign illegal_op = (state == S_DECODE) && !opcode_legal;

endmodule
